vn_lut_loader: RTL and testbench

Sequencer that loads one frame's page set of the two-bank symmetric VN LUT (`sym_vn_rank`) from a symbol stream. It accepts symbols over a valid/ready handshake and pairs them bank0-then-bank1. It issues one dual-bank write per page, walking all pages of the selected frame, then reports completion. It sits between the IB-table configuration source and `sym_vn_rank`'s write port, and owns `we`, `page_write_addr`, `write_addr_offset`, `lut_in_bank0` and `lut_in_bank1`.

---
 rtl/vn_lut_pkg.sv | 25 ++
 rtl/vn_lut_loader_if.sv | 21 ++
 rtl/vn_lut_loader.sv | 121 ++++++++++++
 tb/tb_vn_lut_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vn_lut_pkg.sv
// Shared definitions for the symmetric VN LUT write/read sequencers:
// page geometry for the default LUT shape and the 3-bit state encoding.
package vn_lut_pkg;

  localparam int QUAN_SIZE_DEF       = 3;
  localparam int ENTRY_ADDR_DEF      = 5;
  localparam int MULTI_FRAME_NUM_DEF = 2;

  localparam int PAGE_ADDR_W = ENTRY_ADDR_DEF - $clog2(MULTI_FRAME_NUM_DEF);
  localparam int PAGE_NUM    = 2 ** PAGE_ADDR_W;

  // The read-side page scheduler decodes these exact values.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } load_state_e;

  function automatic logic is_fetch(input load_state_e s);
    return (s == FETCH0) || (s == FETCH1);
  endfunction

endpackage : vn_lut_pkg

// File: rtl/vn_lut_loader_if.sv
// Symbol stream from the IB-table configuration source into the LUT loader.
// The source drives symbols; the loader answers with sym_ready.
interface vn_lut_loader_if #(
  parameter int QUAN_SIZE = 3
);
  logic [QUAN_SIZE-1:0] sym_in;
  logic                 sym_valid;
  logic                 sym_ready;

  modport master (
    output sym_in,
    output sym_valid,
    input  sym_ready
  );

  modport slave (
    input  sym_in,
    input  sym_valid,
    output sym_ready
  );
endinterface : vn_lut_loader_if

// File: rtl/vn_lut_loader.sv
// Loads one frame's page set of the two-bank sym_vn_rank LUT: pairs stream
// symbols bank0-then-bank1 and issues one dual-bank write per page.
module vn_lut_loader
  import vn_lut_pkg::*;
#(
  parameter int QUAN_SIZE       = 3,
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2,
  localparam int PAW            = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM)
) (
  input  logic                 write_clk,
  input  logic                 rstn,
  input  logic                 load_start,
  input  logic                 load_frame,
  input  logic                 abort,
  vn_lut_loader_if.slave       sym,
  output logic [QUAN_SIZE-1:0] lut_in_bank0,
  output logic [QUAN_SIZE-1:0] lut_in_bank1,
  output logic [PAW-1:0]       page_write_addr,
  output logic                 write_addr_offset,
  output logic                 we,
  output logic                 busy,
  output logic                 load_done
);

  localparam logic [PAW-1:0] LAST_PAGE = {PAW{1'b1}};

  load_state_e          state_q, state_d;
  logic [PAW-1:0]       page_q, page_d;
  logic                 offset_q, offset_d;
  logic [QUAN_SIZE-1:0] bank0_q, bank0_d;
  logic [QUAN_SIZE-1:0] bank1_q, bank1_d;

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    offset_d = offset_q;
    bank0_d  = bank0_q;
    bank1_d  = bank1_q;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          offset_d = load_frame;
          page_d   = '0;
          state_d  = FETCH0;
        end
      end

      FETCH0: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sym.sym_valid) begin
          bank0_d = sym.sym_in;
          state_d = FETCH1;
        end
      end

      FETCH1: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sym.sym_valid) begin
          bank1_d = sym.sym_in;
          state_d = WRITE;
        end
      end

      // The write itself is already on the bus this cycle; abort only
      // decides where we go next. Terminal test precedes the increment.
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (page_q == LAST_PAGE) begin
          state_d = DONE;
        end else begin
          page_d  = page_q + 1'b1;
          state_d = FETCH0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      page_q   <= '0;
      offset_q <= 1'b0;
      bank0_q  <= '0;
      bank1_q  <= '0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      offset_q <= offset_d;
      bank0_q  <= bank0_d;
      bank1_q  <= bank1_d;
    end
  end

  // Moore outputs: decoded from registered state only.
  assign sym.sym_ready       = is_fetch(state_q);
  assign we                  = (state_q == WRITE);
  assign busy                = (state_q != IDLE);
  assign load_done           = (state_q == DONE);
  assign page_write_addr     = page_q;
  assign write_addr_offset   = offset_q;
  assign lut_in_bank0        = bank0_q;
  assign lut_in_bank1        = bank1_q;

endmodule : vn_lut_loader

// File: tb/tb_vn_lut_loader.sv
// Self-checking bench for vn_lut_loader: scenario table plus a scoreboard
// of expected page writes built from the accepted symbol stream.
module tb_vn_lut_loader;

  localparam int QS  = 3;
  localparam int PAW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          load_start, load_frame, abort;
  logic [QS-1:0] lut_in_bank0, lut_in_bank1;
  logic [PAW-1:0] page_write_addr;
  logic          write_addr_offset, we, busy, load_done;

  vn_lut_loader_if #(.QUAN_SIZE(QS)) sif ();

  vn_lut_loader #(
    .QUAN_SIZE      (QS),
    .ENTRY_ADDR     (5),
    .MULTI_FRAME_NUM(2)
  ) dut (
    .write_clk        (clk),
    .rstn             (rstn),
    .load_start       (load_start),
    .load_frame       (load_frame),
    .abort            (abort),
    .sym              (sif.slave),
    .lut_in_bank0     (lut_in_bank0),
    .lut_in_bank1     (lut_in_bank1),
    .page_write_addr  (page_write_addr),
    .write_addr_offset(write_addr_offset),
    .we               (we),
    .busy             (busy),
    .load_done        (load_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PAW-1:0] page;
    logic           off;
    logic [QS-1:0]  b0;
    logic [QS-1:0]  b1;
  } wr_t;

  typedef struct {
    logic frame;
    int   vmode;       // 0: valid held high, 1: valid toggles every cycle
    int   abort_page;  // -1: none; else abort during FETCH1 of that page
    int   stray_page;  // -1: none; else pulse load_start at FETCH0 of that page
    int   exp_writes;
    int   exp_syms;
    int   exp_done;
    int   exp_lat;     // cycles from first busy cycle to load_done, -1: skip
  } vec_t;

  int checks   = 0;
  int failures = 0;

  wr_t            exp_q[$];
  int             cyc;
  int             vmode;
  logic [QS-1:0]  next_sym;
  logic [PAW-1:0] m_page;
  logic           m_half, m_off;
  logic [QS-1:0]  m_b0;
  logic           prev_hs;
  int             n_writes, n_done, n_acc, first_busy, done_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sym_ready"}, 32'(sif.sym_ready), 0);
    check({tag, "_we"},        32'(we), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_load_done"}, 32'(load_done), 0);
    check({tag, "_page"},      32'(page_write_addr), 0);
    check({tag, "_offset"},    32'(write_addr_offset), 0);
    check({tag, "_bank0"},     32'(lut_in_bank0), 0);
    check({tag, "_bank1"},     32'(lut_in_bank1), 0);
  endtask

  // One clock: monitor/scoreboard at the falling edge, then step past the
  // rising edge and drive the next symbol.
  task automatic cycle();
    wr_t got, want;
    @(negedge clk);
    cyc++;
    if (busy && first_busy < 0) first_busy = cyc;
    if (we) begin
      n_writes++;
      check("we_after_fetch1_handshake", 32'(prev_hs), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(we), 0);
      end else begin
        want = exp_q.pop_front();
        got  = '{page: page_write_addr, off: write_addr_offset,
                 b0: lut_in_bank0, b1: lut_in_bank1};
        check("write_contents", 32'(got), 32'(want));
      end
    end
    if (load_done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_hs = 1'b0;
    if (!busy && load_start) begin
      m_page = '0;
      m_half = 1'b0;
      m_off  = load_frame;
    end else if (busy && abort) begin
      m_half = 1'b0;
    end else if (sif.sym_valid && sif.sym_ready) begin
      n_acc++;
      if (!m_half) begin
        m_b0   = sif.sym_in;
        m_half = 1'b1;
      end else begin
        exp_q.push_back('{page: m_page, off: m_off, b0: m_b0, b1: sif.sym_in});
        m_page  = m_page + 1'b1;
        m_half  = 1'b0;
        prev_hs = 1'b1;
      end
      next_sym = next_sym + 1'b1;
    end
    @(posedge clk);
    #1;
    sif.sym_in    = next_sym;
    sif.sym_valid = (vmode == 0) ? 1'b1 : 1'(cyc[0]);
  endtask

  task automatic run_load(input vec_t v, input int idx);
    string tag;
    logic  aborted, stray_done, finished;
    tag        = $sformatf("vec%0d", idx);
    aborted    = 1'b0;
    stray_done = 1'b0;
    n_writes   = 0;
    n_done     = 0;
    n_acc      = 0;
    first_busy = -1;
    done_cyc   = -1;
    next_sym   = '0;
    vmode      = v.vmode;
    sif.sym_in    = '0;
    sif.sym_valid = (v.vmode == 0);

    load_start = 1'b1;
    load_frame = v.frame;
    cycle();
    load_start = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (n_done > 0 || (aborted && !busy)) break;
      if (v.abort_page >= 0 && !aborted && int'(m_page) == v.abort_page &&
          m_half && sif.sym_ready) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end
      if (v.stray_page >= 0 && !stray_done && int'(m_page) == v.stray_page && !m_half) begin
        load_start = 1'b1;
        load_frame = ~v.frame;
        stray_done = 1'b1;
      end
      cycle();
      if (abort) begin
        check({tag, "_idle_after_abort"}, 32'(busy), 0);
        check({tag, "_ready_after_abort"}, 32'(sif.sym_ready), 0);
      end
      abort      = 1'b0;
      load_start = 1'b0;
    end
    finished = (n_done > 0) || (aborted && !busy);
    check({tag, "_finished_in_budget"}, 32'(finished), 1);
    repeat (4) cycle();
    check({tag, "_write_count"}, n_writes, v.exp_writes);
    check({tag, "_symbols_accepted"}, n_acc, v.exp_syms);
    check({tag, "_done_pulses"}, n_done, v.exp_done);
    check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
    check({tag, "_idle_at_end"}, 32'(busy), 0);
    if (v.exp_lat >= 0) check({tag, "_done_latency"}, done_cyc - first_busy, v.exp_lat);
  endtask

  vec_t vecs[5];

  initial begin
    // First FETCH0 counts as cycle 1 of 49, so load_done lands 48 edges later.
    vecs[0] = '{frame: 1'b1, vmode: 0, abort_page: -1, stray_page: -1,
                exp_writes: 16, exp_syms: 32, exp_done: 1, exp_lat: 48};
    vecs[1] = '{frame: 1'b1, vmode: 1, abort_page: -1, stray_page: -1,
                exp_writes: 16, exp_syms: 32, exp_done: 1, exp_lat: -1};
    vecs[2] = '{frame: 1'b1, vmode: 0, abort_page: 5, stray_page: -1,
                exp_writes: 5, exp_syms: 11, exp_done: 0, exp_lat: -1};
    vecs[3] = '{frame: 1'b0, vmode: 0, abort_page: -1, stray_page: -1,
                exp_writes: 16, exp_syms: 32, exp_done: 1, exp_lat: 48};
    vecs[4] = '{frame: 1'b1, vmode: 0, abort_page: -1, stray_page: 7,
                exp_writes: 16, exp_syms: 32, exp_done: 1, exp_lat: 48};

    cyc = 0; vmode = 0; next_sym = '0;
    m_page = '0; m_half = 1'b0; m_off = 1'b0; m_b0 = '0; prev_hs = 1'b0;
    rstn = 1'b0; load_start = 1'b0; load_frame = 1'b0; abort = 1'b0;
    sif.sym_in = '0; sif.sym_valid = 1'b0;
    #12;
    check_reset_vals("por");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // abort and load_start together in IDLE: start wins
    abort      = 1'b1;
    load_start = 1'b1;
    load_frame = 1'b0;
    @(posedge clk);
    #1;
    check("start_beats_abort_busy", 32'(busy), 1);
    abort      = 1'b0;
    load_start = 1'b0;
    rstn       = 1'b0;
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_load(vecs[i], i);

    // Asynchronous reset in the middle of a WRITE cycle.
    vmode = 0;
    next_sym = '0;
    sif.sym_valid = 1'b1;
    load_start = 1'b1;
    load_frame = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    for (int t = 0; t < 20 && !we; t++) begin
      @(posedge clk);
      #1;
    end
    check("we_seen_before_reset", 32'(we), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("we_drops_async", 32'(we), 0);
    check_reset_vals("midrst");
    @(posedge clk);
    #2;
    rstn = 1'b1;
    exp_q.delete();
    m_half = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1;
      check("ready_low_after_reset", 32'(sif.sym_ready), 0);
    end
    load_start = 1'b1;
    load_frame = 1'b0;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    check("ready_after_restart", 32'(sif.sym_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vn_lut_loader
